// File: rtl/clause_scheduler_pkg.sv
// Shared types and constants for the clause scheduler: FSM states, clause record
// sizing and the boolean literal encodings understood by the one-clause checker.
package clause_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Literal code: bit1 = literal present, bit0 = value the variable must take.
    localparam logic [1:0] NOT_EXIST  = 2'b00;
    localparam logic [1:0] EXIST_ZERO = 2'b10;
    localparam logic [1:0] EXIST_ONE  = 2'b11;

    // Record = integer coefficients plus bias, then 2-bit boolean literal codes.
    function automatic int clause_record_width(input int icw, input int iv, input int bv);
        return ((1 << iv) + 1) * icw + (1 << bv) * 2;
    endfunction

endpackage

// File: rtl/clause_scheduler_if.sv
// Link between the clause scheduler (master) and a single one-clause checker (slave).
interface clause_scheduler_if #(
    parameter int INT_W  = 12,
    parameter int BOOL_W = 4
);
    logic              out_chk_enable;
    logic [INT_W-1:0]  out_chk_int_coeffs;
    logic [BOOL_W-1:0] out_chk_bool_coeffs;
    logic              in_chk_ready;
    logic              in_chk_satisfied;

    modport master (
        output out_chk_enable, out_chk_int_coeffs, out_chk_bool_coeffs,
        input  in_chk_ready, in_chk_satisfied
    );

    modport slave (
        input  out_chk_enable, out_chk_int_coeffs, out_chk_bool_coeffs,
        output in_chk_ready, in_chk_satisfied
    );
endinterface

// File: rtl/clause_scheduler_memory.sv
// Clause record register file: one synchronous write port, one combinational read
// port, contents deliberately left unreset.
module clause_memory #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              in_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge in_clk) begin
            if (wr_en && wr_addr == ADDR_W'(gi)) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/clause_scheduler.sv
// Walks the stored clauses through one checker, collecting per-clause verdicts,
// the unsatisfied count and the lowest unsatisfied index for the MCMC loop.
module clause_scheduler
    import clause_scheduler_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 3,
    parameter int CHECKER_TIMEOUT                             = 4,
    localparam int ICW    = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int IV     = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int BV     = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int CI     = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int INT_W  = ((1 << IV) + 1) * ICW,
    localparam int BOOL_W = (1 << BV) * 2,
    localparam int DEPTH  = 1 << CI
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic                      in_wr_en,
    input  logic [CI-1:0]             in_wr_addr,
    input  logic [INT_W-1:0]          in_wr_int_coeffs,
    input  logic [BOOL_W-1:0]         in_wr_bool_coeffs,
    input  logic [CI:0]               in_num_clauses,
    input  logic                      in_start,
    clause_scheduler_if.master        chk,
    output logic                      out_busy,
    output logic                      out_done,
    output logic [DEPTH-1:0]          out_sat_vector,
    output logic [CI:0]               out_unsat_count,
    output logic [CI-1:0]             out_first_unsat_index,
    output logic                      out_all_satisfied,
    output logic                      out_timeout
);
    localparam int REC_W = clause_record_width(ICW, IV, BV);
    localparam int CNT_W = CI + 1;
    localparam int TO_W  = $clog2(CHECKER_TIMEOUT + 1);

    state_t              state_reg;
    logic [CI-1:0]       k_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [TO_W-1:0]     timeout_cnt_reg;
    logic                chk_enable_reg;
    logic [INT_W-1:0]    chk_int_reg;
    logic [BOOL_W-1:0]   chk_bool_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [DEPTH-1:0]    sat_vector_reg;
    logic [CNT_W-1:0]    unsat_count_reg;
    logic [CI-1:0]       first_unsat_reg;
    logic                all_sat_reg;
    logic                timeout_reg;

    logic                wr_accept;
    logic [REC_W-1:0]    wr_record;
    logic [CI-1:0]       rd_addr;
    logic [REC_W-1:0]    rd_data;
    logic [REC_W-1:0]    fetch_record;
    logic [CNT_W-1:0]    eff_count;
    logic [TO_W-1:0]     timeout_cnt_next;

    // The memory is frozen whenever a pass is in flight.
    assign wr_accept = in_wr_en && (state_reg == ST_IDLE);
    assign wr_record = {in_wr_bool_coeffs, in_wr_int_coeffs};
    assign rd_addr   = (state_reg == ST_IDLE) ? '0 : k_reg + CI'(1);

    // A write landing on the same edge as in_start must be seen by the first fetch.
    assign fetch_record = (wr_accept && in_wr_addr == rd_addr) ? wr_record : rd_data;

    assign eff_count = (in_num_clauses > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : in_num_clauses;
    assign timeout_cnt_next = timeout_cnt_reg + TO_W'(1);

    clause_memory #(
        .ADDR_W (CI),
        .DATA_W (REC_W)
    ) u_clause_memory (
        .in_clk  (in_clk),
        .wr_en   (wr_accept),
        .wr_addr (in_wr_addr),
        .wr_data (wr_record),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_reg       <= ST_IDLE;
            k_reg           <= '0;
            count_reg       <= '0;
            timeout_cnt_reg <= '0;
            chk_enable_reg  <= 1'b0;
            chk_int_reg     <= '0;
            chk_bool_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            sat_vector_reg  <= '0;
            unsat_count_reg <= '0;
            first_unsat_reg <= '0;
            all_sat_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (in_start) begin
                        sat_vector_reg  <= '0;
                        unsat_count_reg <= '0;
                        first_unsat_reg <= '0;
                        all_sat_reg     <= 1'b0;
                        timeout_reg     <= 1'b0;
                        busy_reg        <= 1'b1;
                        k_reg           <= '0;
                        count_reg       <= eff_count;
                        timeout_cnt_reg <= '0;
                        if (eff_count == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg      <= ST_ISSUE;
                            chk_enable_reg <= 1'b1;
                            chk_int_reg    <= fetch_record[INT_W-1:0];
                            chk_bool_reg   <= fetch_record[REC_W-1:INT_W];
                        end
                    end
                end
                ST_ISSUE: begin
                    chk_enable_reg  <= 1'b0;
                    timeout_cnt_reg <= '0;
                    state_reg       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (chk.in_chk_ready) begin
                        sat_vector_reg[k_reg] <= chk.in_chk_satisfied;
                        if (!chk.in_chk_satisfied) begin
                            unsat_count_reg <= unsat_count_reg + CNT_W'(1);
                            if (unsat_count_reg == '0) begin
                                first_unsat_reg <= k_reg;
                            end
                        end
                        if ({1'b0, k_reg} == count_reg - CNT_W'(1)) begin
                            state_reg <= ST_DONE;
                        end else begin
                            k_reg          <= k_reg + CI'(1);
                            state_reg      <= ST_ISSUE;
                            chk_enable_reg <= 1'b1;
                            chk_int_reg    <= fetch_record[INT_W-1:0];
                            chk_bool_reg   <= fetch_record[REC_W-1:INT_W];
                        end
                    end else if (timeout_cnt_next == TO_W'(CHECKER_TIMEOUT)) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_next;
                    end
                end
                ST_DONE: begin
                    done_reg    <= 1'b1;
                    all_sat_reg <= (unsat_count_reg == '0) && !timeout_reg;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign chk.out_chk_enable      = chk_enable_reg;
    assign chk.out_chk_int_coeffs  = chk_int_reg;
    assign chk.out_chk_bool_coeffs = chk_bool_reg;
    assign out_busy                = busy_reg;
    assign out_done                = done_reg;
    assign out_sat_vector          = sat_vector_reg;
    assign out_unsat_count         = unsat_count_reg;
    assign out_first_unsat_index   = first_unsat_reg;
    assign out_all_satisfied       = all_sat_reg;
    assign out_timeout             = timeout_reg;
endmodule

// File: tb/tb_clause_scheduler.sv
// Randomised scoreboard bench for clause_scheduler with an emulated one-clause checker.
module tb_clause_scheduler;
    import clause_scheduler_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 4;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_wr_en = 1'b0;
    logic [2:0]  in_wr_addr = '0;
    logic [11:0] in_wr_int_coeffs = '0;
    logic [3:0]  in_wr_bool_coeffs = '0;
    logic [3:0]  in_num_clauses = '0;
    logic        in_start = 1'b0;
    logic        out_busy, out_done, out_all_satisfied, out_timeout;
    logic [7:0]  out_sat_vector;
    logic [3:0]  out_unsat_count;
    logic [2:0]  out_first_unsat_index;

    clause_scheduler_if #(.INT_W(12), .BOOL_W(4)) bus ();

    clause_scheduler dut (
        .in_clk                (in_clk),
        .in_reset              (in_reset),
        .in_wr_en              (in_wr_en),
        .in_wr_addr            (in_wr_addr),
        .in_wr_int_coeffs      (in_wr_int_coeffs),
        .in_wr_bool_coeffs     (in_wr_bool_coeffs),
        .in_num_clauses        (in_num_clauses),
        .in_start              (in_start),
        .chk                   (bus),
        .out_busy              (out_busy),
        .out_done              (out_done),
        .out_sat_vector        (out_sat_vector),
        .out_unsat_count       (out_unsat_count),
        .out_first_unsat_index (out_first_unsat_index),
        .out_all_satisfied     (out_all_satisfied),
        .out_timeout           (out_timeout)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [7:0] sv;
        logic [3:0] cnt;
        logic [2:0] first;
        logic       all_sat;
        logic       tmo;
        int         done_cycle;
    } res_t;

    logic [15:0] mem_model [DEPTH];
    res_t        exp_res_q[$];
    logic [15:0] exp_issue_q[$];
    res_t        last_res;
    int          delay_arr [DEPTH];
    int          x_int [2];
    bit          b_val [2];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          pass_seq = 0;
    int          done_count = 0;

    always @(posedge in_clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Clause meaning used by the emulated checker: any present literal that matches,
    // or the linear part a0*x0 + a1*x1 + bias <= 0.
    function automatic bit clause_sat(input logic [15:0] r);
        int a0, a1, bias;
        logic [1:0] code;
        a0 = $signed(r[3:0]);
        a1 = $signed(r[7:4]);
        bias = $signed(r[11:8]);
        for (int j = 0; j < 2; j++) begin
            code = r[12 + 2*j +: 2];
            if (code[1] && (code[0] == b_val[j])) return 1'b1;
        end
        return (a0 * x_int[0] + a1 * x_int[1] + bias) <= 0;
    endfunction

    // Reference model: what a pass over the first min(n,8) clauses must report.
    task automatic expect_pass(input int n);
        res_t r;
        int neff, lat;
        neff = (n > DEPTH) ? DEPTH : n;
        r.sv = '0; r.cnt = '0; r.first = '0; r.tmo = 1'b0; lat = 0;
        for (int k = 0; k < neff; k++) begin
            exp_issue_q.push_back(mem_model[k]);
            if (delay_arr[k] > TMO) begin
                lat += 1 + TMO;
                r.tmo = 1'b1;
                break;
            end
            lat += 1 + delay_arr[k];
            if (clause_sat(mem_model[k])) r.sv[k] = 1'b1;
            else begin
                if (r.cnt == 0) r.first = 3'(k);
                r.cnt = r.cnt + 4'd1;
            end
        end
        lat += 1;
        r.all_sat = (r.cnt == 0) && !r.tmo;
        r.done_cycle = cycle + 1 + lat;
        exp_res_q.push_back(r);
        $display("pass %0d: n=%0d exp sv=%b cnt=%0d first=%0d all=%0d tmo=%0d done@%0d",
                 pass_seq, n, r.sv, r.cnt, r.first, r.all_sat, r.tmo, r.done_cycle);
    endtask

    // Emulated checker: answers the k-th issue of a pass after delay_arr[k] WAIT cycles.
    initial begin
        int cd, idx, seen;
        logic [15:0] lat_rec;
        cd = 0; idx = 0; seen = 0; lat_rec = '0;
        bus.in_chk_ready = 1'b0;
        bus.in_chk_satisfied = 1'b0;
        forever begin
            @(negedge in_clk);
            if (in_reset) begin
                cd = 0;
                bus.in_chk_ready = 1'b0;
            end else begin
                if (seen != pass_seq) begin seen = pass_seq; idx = 0; end
                if (bus.out_chk_enable) begin
                    cd = delay_arr[idx % DEPTH];
                    idx++;
                    lat_rec = {bus.out_chk_bool_coeffs, bus.out_chk_int_coeffs};
                    bus.in_chk_ready = 1'b0;
                end else if (cd > 0) begin
                    cd--;
                    bus.in_chk_ready = (cd == 0);
                    bus.in_chk_satisfied = clause_sat(lat_rec);
                end else begin
                    bus.in_chk_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected issues and results whenever the DUT presents them.
    initial begin
        logic [15:0] e;
        res_t r;
        forever begin
            @(negedge in_clk);
            if (!in_reset) begin
                if (bus.out_chk_enable) begin
                    if (exp_issue_q.size() == 0) chk("unexpected_issue", 1, 0);
                    else begin
                        e = exp_issue_q.pop_front();
                        chk("issue_coeffs", int'({bus.out_chk_bool_coeffs, bus.out_chk_int_coeffs}), int'(e));
                    end
                    chk("busy_in_pass", int'(out_busy), 1);
                end
                if (out_done) begin
                    done_count++;
                    if (exp_res_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        r = exp_res_q.pop_front();
                        chk("done_cycle", cycle, r.done_cycle);
                        chk("sat_vector", int'(out_sat_vector), int'(r.sv));
                        chk("unsat_count", int'(out_unsat_count), int'(r.cnt));
                        chk("first_unsat", int'(out_first_unsat_index), int'(r.first));
                        chk("all_satisfied", int'(out_all_satisfied), int'(r.all_sat));
                        chk("timeout", int'(out_timeout), int'(r.tmo));
                        chk("busy_at_done", int'(out_busy), 0);
                        last_res = r;
                    end
                end
            end
        end
    end

    task automatic do_write(input int addr, input logic [15:0] rec);
        @(negedge in_clk);
        in_wr_en = 1'b1;
        in_wr_addr = 3'(addr);
        in_wr_int_coeffs = rec[11:0];
        in_wr_bool_coeffs = rec[15:12];
        mem_model[addr] = rec;
        @(negedge in_clk);
        in_wr_en = 1'b0;
    endtask

    task automatic start_pass(input int n, input bit wr, input int addr, input logic [15:0] rec);
        @(negedge in_clk);
        if (wr) begin
            in_wr_en = 1'b1;
            in_wr_addr = 3'(addr);
            in_wr_int_coeffs = rec[11:0];
            in_wr_bool_coeffs = rec[15:12];
            mem_model[addr] = rec;
        end
        expect_pass(n);
        pass_seq++;
        in_num_clauses = 4'(n);
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_wr_en = 1'b0;
    endtask

    task automatic wait_pass();
        int guard;
        guard = 0;
        while (exp_res_q.size() != 0 && guard < 300) begin
            @(posedge in_clk);
            guard++;
        end
        if (guard >= 300) begin
            chk("pass_wait_bound", 0, 1);
            exp_res_q.delete();
        end
        @(negedge in_clk);
        chk("issues_consumed", exp_issue_q.size(), 0);
        exp_issue_q.delete();
        repeat (3) @(negedge in_clk);
        chk("hold_sat_vector", int'(out_sat_vector), int'(last_res.sv));
        chk("hold_unsat_count", int'(out_unsat_count), int'(last_res.cnt));
        chk("hold_all_satisfied", int'(out_all_satisfied), int'(last_res.all_sat));
        chk("hold_done_low", int'(out_done), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(out_busy), 0);
        chk({tag, "_done"}, int'(out_done), 0);
        chk({tag, "_sat_vector"}, int'(out_sat_vector), 0);
        chk({tag, "_unsat_count"}, int'(out_unsat_count), 0);
        chk({tag, "_first_unsat"}, int'(out_first_unsat_index), 0);
        chk({tag, "_all_satisfied"}, int'(out_all_satisfied), 0);
        chk({tag, "_timeout"}, int'(out_timeout), 0);
        chk({tag, "_chk_enable"}, int'(bus.out_chk_enable), 0);
        chk({tag, "_chk_coeffs"}, int'({bus.out_chk_bool_coeffs, bus.out_chk_int_coeffs}), 0);
    endtask

    task automatic set_delays(input int d);
        for (int k = 0; k < DEPTH; k++) delay_arr[k] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [15:0] sat_rec, unsat3_rec, unsat5_rec;
        sat_rec    = {NOT_EXIST, NOT_EXIST, 4'hF, 8'h00};
        unsat3_rec = {NOT_EXIST, NOT_EXIST, 4'h3, 8'h00};
        unsat5_rec = {NOT_EXIST, NOT_EXIST, 4'h5, 8'h00};
        x_int[0] = 1; x_int[1] = -2; b_val[0] = 1'b0; b_val[1] = 1'b1;
        set_delays(1);
        last_res = '{default: '0};

        repeat (2) @(negedge in_clk);
        check_zero("reset");
        in_reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) do_write(a, 16'($urandom()));

        // T1: three trivially satisfied clauses, fixed 1-cycle checker
        for (int a = 0; a < 3; a++) do_write(a, sat_rec);
        start_pass(3, 1'b0, 0, '0);
        wait_pass();

        // T2: clause 1 unsatisfiable
        do_write(1, unsat3_rec);
        start_pass(3, 1'b0, 0, '0);
        wait_pass();

        // T3: empty pass
        start_pass(0, 1'b0, 0, '0);
        wait_pass();

        // T4: checker never answers
        set_delays(6);
        start_pass(2, 1'b0, 0, '0);
        wait_pass();

        // T5: start and write while busy are both ignored
        set_delays(1);
        do_write(7, sat_rec);
        snap = done_count;
        start_pass(8, 1'b0, 0, '0);
        repeat (4) @(negedge in_clk);
        in_start = 1'b1;
        in_wr_en = 1'b1;
        in_wr_addr = 3'd7;
        in_wr_int_coeffs = unsat5_rec[11:0];
        in_wr_bool_coeffs = unsat5_rec[15:12];
        @(negedge in_clk);
        in_start = 1'b0;
        in_wr_en = 1'b0;
        wait_pass();
        repeat (20) @(negedge in_clk);
        chk("single_done_t5", done_count - snap, 1);
        start_pass(8, 1'b0, 0, '0);
        wait_pass();

        // T6: asynchronous reset while waiting on clause 2
        start_pass(8, 1'b0, 0, '0);
        repeat (5) @(posedge in_clk);
        #2;
        in_reset = 1'b1;
        #1;
        check_zero("async_reset");
        exp_res_q.delete();
        exp_issue_q.delete();
        snap = done_count;
        repeat (2) @(negedge in_clk);
        #2;
        in_reset = 1'b0;
        repeat (20) @(negedge in_clk);
        chk("no_done_after_reset", done_count - snap, 0);
        start_pass(8, 1'b0, 0, '0);
        wait_pass();

        // Randomised passes: random clauses, assignments, counts, latencies, same-edge writes
        for (int p = 0; p < 14; p++) begin
            for (int w = 0; w < 3; w++) do_write(int'($urandom_range(0, DEPTH - 1)), 16'($urandom()));
            x_int[0] = int'($urandom_range(0, 15)) - 8;
            x_int[1] = int'($urandom_range(0, 15)) - 8;
            b_val[0] = 1'($urandom());
            b_val[1] = 1'($urandom());
            for (int k = 0; k < DEPTH; k++)
                delay_arr[k] = ($urandom_range(0, 11) == 0) ? 5 : int'($urandom_range(1, TMO));
            start_pass(int'($urandom_range(0, 10)), ($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, 2)), 16'($urandom()));
            wait_pass();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
